// File: rtl/clk_enable_sequencer.sv
// clk_enable_sequencer
//   Brings up to N_CLK clock generator enables up in ascending order and
//   takes them down in descending order. Each stage waits its own gap
//   count from the latched dly_cfg before it changes.
//
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high; clears all state at once
//   start      : single-cycle request to begin power-up (IDLE only)
//   stop       : single-cycle request to begin power-down (RUN) or abort (UP)
//   dly_cfg    : per-stage gap, slice k = [k*DLY_W +: DLY_W]
//   clk_en     : registered generator enables, contiguous from bit 0
//   busy       : high while sequencing (UP or DOWN)
//   running    : high while every stage is enabled (RUN)
//   up_done    : one-cycle pulse on the edge the last stage is enabled
//   down_done  : one-cycle pulse on the edge the sequencer returns to IDLE
module clk_enable_sequencer #(
  parameter int N_CLK = 4,
  parameter int DLY_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [N_CLK*DLY_W-1:0] dly_cfg,
  output logic [N_CLK-1:0]       clk_en,
  output logic                   busy,
  output logic                   running,
  output logic                   up_done,
  output logic                   down_done
);

  localparam int IDX_W = (N_CLK > 1) ? $clog2(N_CLK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_RUN  = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [DLY_W-1:0]       r_cnt, w_cnt_nxt;
  logic [N_CLK*DLY_W-1:0] r_dly_q, w_dly_nxt;
  logic [N_CLK-1:0]       r_clk_en, w_clk_en_nxt;
  logic                   r_up_done, w_up_done_nxt;
  logic                   r_down_done, w_down_done_nxt;

  // Gap for stage k; out-of-range k returns 0 so neighbour lookups at the
  // ends of the chain stay in bounds for any N_CLK.
  function automatic logic [DLY_W-1:0] stage_dly(
    input logic [N_CLK*DLY_W-1:0] vec,
    input int                     k
  );
    logic [DLY_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_CLK; i++) begin
      if (i == k) v = vec[i*DLY_W +: DLY_W];
    end
    return v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_dly_q     <= '0;
      r_clk_en    <= '0;
      r_up_done   <= 1'b0;
      r_down_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dly_q     <= w_dly_nxt;
      r_clk_en    <= w_clk_en_nxt;
      r_up_done   <= w_up_done_nxt;
      r_down_done <= w_down_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_dly_nxt       = r_dly_q;
    w_clk_en_nxt    = r_clk_en;
    w_up_done_nxt   = 1'b0;
    w_down_done_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        // stop beats start when both arrive together
        if (start && !stop) begin
          w_dly_nxt   = dly_cfg;
          w_idx_nxt   = '0;
          w_cnt_nxt   = stage_dly(dly_cfg, 0);
          w_state_nxt = S_UP;
        end
      end

      S_UP: begin
        if (stop) begin
          // Abort: stage idx is still off, so unwind from the one below it.
          if (r_idx == '0) begin
            w_state_nxt     = S_IDLE;
            w_down_done_nxt = 1'b1;
          end else begin
            w_idx_nxt   = r_idx - IDX_W'(1);
            w_cnt_nxt   = stage_dly(r_dly_q, int'(r_idx) - 1);
            w_state_nxt = S_DOWN;
          end
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DLY_W'(1);
        end else begin
          w_clk_en_nxt[r_idx] = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt   = S_RUN;
            w_up_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
            w_cnt_nxt = stage_dly(r_dly_q, int'(r_idx) + 1);
          end
        end
      end

      S_RUN: begin
        if (stop) begin
          w_idx_nxt   = LAST_IDX;
          w_cnt_nxt   = stage_dly(r_dly_q, N_CLK - 1);
          w_state_nxt = S_DOWN;
        end
      end

      S_DOWN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DLY_W'(1);
        end else begin
          w_clk_en_nxt[r_idx] = 1'b0;
          if (r_idx == '0) begin
            w_state_nxt     = S_IDLE;
            w_down_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx - IDX_W'(1);
            w_cnt_nxt = stage_dly(r_dly_q, int'(r_idx) - 1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign clk_en    = r_clk_en;
  assign busy      = (r_state == S_UP) || (r_state == S_DOWN);
  assign running   = (r_state == S_RUN);
  assign up_done   = r_up_done;
  assign down_done = r_down_done;

endmodule

// File: tb/tb_clk_enable_sequencer.sv
// Directed bench for clk_enable_sequencer (N_CLK=4, DLY_W=8).
// Every check compares the packed vector {clk_en, busy, running, up_done,
// down_done} against hand-computed expectations, sampled 1 ns after the
// rising edge. "rel" counts edges after the edge that sampled start/stop.
module tb_clk_enable_sequencer;

  localparam int N_CLK = 4;
  localparam int DLY_W = 8;

  logic                   clock;
  logic                   reset;
  logic                   start;
  logic                   stop;
  logic [N_CLK*DLY_W-1:0] dly_cfg;
  logic [N_CLK-1:0]       clk_en;
  logic                   busy;
  logic                   running;
  logic                   up_done;
  logic                   down_done;

  int checks;
  int passes;

  clk_enable_sequencer #(.N_CLK(N_CLK), .DLY_W(DLY_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .dly_cfg   (dly_cfg),
    .clk_en    (clk_en),
    .busy      (busy),
    .running   (running),
    .up_done   (up_done),
    .down_done (down_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs, exp;
    reset = 1'b1; start = 1'b1; stop = 1'b0; dly_cfg = '0;
    tick(); tick();
    start = 1'b0;
    obs = {clk_en, busy, running, up_done, down_done}; exp = 8'h00;
    checks++;
    if (obs !== exp) $display("FAIL reset_hold got=%b want=%b", obs, exp);
    else passes++;
    reset = 1'b0;
    tick();
    obs = {clk_en, busy, running, up_done, down_done};
    checks++;
    if (obs !== exp) $display("FAIL reset_release got=%b want=%b", obs, exp);
    else passes++;
  endtask

  // Bits rise at rel 4,5,11,13 for gaps 3,0,5,1; a start at rel 6 and a
  // dly_cfg change after the accepted start must not disturb anything.
  task automatic test_up();
    logic [7:0] obs, exp;
    logic [3:0] en;
    int rise [4];
    rise = '{4, 5, 11, 13};
    dly_cfg = {8'd1, 8'd5, 8'd0, 8'd3};
    start = 1'b1;
    tick();
    start = 1'b0;
    dly_cfg = '1;
    for (int rel = 0; rel <= 16; rel++) begin
      if (rel > 0) tick();
      en = '0;
      for (int k = 0; k < 4; k++) if (rel >= rise[k]) en[k] = 1'b1;
      exp = {en, rel < 13, rel >= 13, rel == 13, 1'b0};
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL up_seq rel=%0d got=%b want=%b", rel, obs, exp);
      else passes++;
      start = (rel == 5);
    end
    start = 1'b0;
  endtask

  // From RUN: start is ignored; stop gives falls at rel 2,8,9,13 for bits
  // 3,2,1,0. A second stop and a start during DOWN are ignored.
  task automatic test_down();
    logic [7:0] obs, exp;
    logic [3:0] en;
    int fall [4];
    fall = '{13, 9, 8, 2};
    start = 1'b1;
    tick();
    start = 1'b0;
    obs = {clk_en, busy, running, up_done, down_done}; exp = 8'hF4;
    checks++;
    if (obs !== exp) $display("FAIL run_start_ignored got=%b want=%b", obs, exp);
    else passes++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    dly_cfg = '0;
    for (int rel = 0; rel <= 16; rel++) begin
      if (rel > 0) tick();
      en = '0;
      for (int k = 0; k < 4; k++) if (rel < fall[k]) en[k] = 1'b1;
      exp = {en, rel < 13, 1'b0, 1'b0, rel == 13};
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL down_seq rel=%0d got=%b want=%b", rel, obs, exp);
      else passes++;
      stop  = (rel == 3);
      start = (rel == 5);
    end
    stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_idle_ignore();
    logic [7:0] obs, exp;
    dly_cfg = {8'd1, 8'd1, 8'd1, 8'd1};
    exp = 8'h00;
    for (int i = 0; i < 4; i++) begin
      stop  = 1'b1;
      start = (i < 2);
      tick();
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL idle_ignore i=%0d got=%b want=%b", i, obs, exp);
      else passes++;
    end
    stop = 1'b0; start = 1'b0;
    tick();
    obs = {clk_en, busy, running, up_done, down_done};
    checks++;
    if (obs !== exp) $display("FAIL idle_settle got=%b want=%b", obs, exp);
    else passes++;
  endtask

  // Gaps all 4: bit0 up at rel 5, stop at rel 7 while bit1 pends, bit0
  // falls at rel 12 with down_done.
  task automatic test_abort();
    logic [7:0] obs, exp;
    dly_cfg = {8'd4, 8'd4, 8'd4, 8'd4};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int rel = 0; rel <= 14; rel++) begin
      if (rel > 0) tick();
      exp = {3'b000, (rel >= 5) && (rel < 12), rel < 12, 1'b0, 1'b0, rel == 12};
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL abort rel=%0d got=%b want=%b", rel, obs, exp);
      else passes++;
      stop = (rel == 6);
    end
    stop = 1'b0;
  endtask

  task automatic test_abort_idx0();
    logic [7:0] obs, exp;
    dly_cfg = {8'd0, 8'd0, 8'd0, 8'd10};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int rel = 0; rel <= 5; rel++) begin
      if (rel > 0) tick();
      exp = {4'b0000, rel < 3, 1'b0, 1'b0, rel == 3};
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL abort_idx0 rel=%0d got=%b want=%b", rel, obs, exp);
      else passes++;
      stop = (rel == 2);
    end
    stop = 1'b0;
  endtask

  // Zero gaps: stop sampled while cnt=0 and bit1 is due must not set bit1.
  task automatic test_zero_gap_abort();
    logic [7:0] obs, exp;
    dly_cfg = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int rel = 0; rel <= 5; rel++) begin
      if (rel > 0) tick();
      exp = {3'b000, (rel >= 1) && (rel < 3), rel < 3, 1'b0, 1'b0, rel == 3};
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL zero_gap_abort rel=%0d got=%b want=%b", rel, obs, exp);
      else passes++;
      stop = (rel == 1);
    end
    stop = 1'b0;
  endtask

  // Reset with two bits up, then a full up/down with new gaps of 2.
  task automatic test_reset_mid();
    logic [7:0] obs, exp;
    logic [3:0] en;
    dly_cfg = {8'd1, 8'd1, 8'd1, 8'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int rel = 0; rel <= 4; rel++) begin
      if (rel > 0) tick();
      exp = {2'b00, rel >= 4, rel >= 2, 1'b1, 1'b0, 1'b0, 1'b0};
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL pre_reset rel=%0d got=%b want=%b", rel, obs, exp);
      else passes++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp = 8'h00;
    for (int i = 0; i < 2; i++) begin
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL mid_reset i=%0d got=%b want=%b", i, obs, exp);
      else passes++;
      tick();
    end
    dly_cfg = {8'd2, 8'd2, 8'd2, 8'd2};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int rel = 0; rel <= 13; rel++) begin
      if (rel > 0) tick();
      en = '0;
      for (int k = 0; k < 4; k++) if (rel >= 3 * (k + 1)) en[k] = 1'b1;
      exp = {en, rel < 12, rel >= 12, rel == 12, 1'b0};
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL new_cfg_up rel=%0d got=%b want=%b", rel, obs, exp);
      else passes++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int rel = 0; rel <= 13; rel++) begin
      if (rel > 0) tick();
      en = '0;
      for (int k = 0; k < 4; k++) if (rel < 3 * (4 - k)) en[k] = 1'b1;
      exp = {en, rel < 12, 1'b0, 1'b0, rel == 12};
      obs = {clk_en, busy, running, up_done, down_done};
      checks++;
      if (obs !== exp) $display("FAIL new_cfg_down rel=%0d got=%b want=%b", rel, obs, exp);
      else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_up();
    test_down();
    test_idle_ignore();
    test_abort();
    test_abort_idx0();
    test_zero_gap_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
